// File: rtl/param_burst_master_pkg.sv
// Shared definitions for the parameter-interface burst master: FSM state
// encoding, peripheral-bus write strobes and responder register offsets.
package param_burst_master_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      WR,
      RD,
      RDCAP,
      RDHOLD,
      DONE
   } state_t;

   // Byte strobes on PerWr: full-word write or plain read.
   localparam logic [1:0] PER_WR_WORD = 2'b11;
   localparam logic [1:0] PER_RD      = 2'b00;

   // Word offsets of the responder's registers from its base word address.
   localparam logic [13:0] OFS_ADDR = 14'd0;
   localparam logic [13:0] OFS_DATA = 14'd1;

   // Word address of a responder register given its byte base address.
   function automatic logic [13:0] word_addr(input logic [15:0] base, input logic [13:0] ofs);
      return 14'(base >> 1) + ofs;
   endfunction

endpackage

// File: rtl/param_burst_master_per_bus_drive.sv
// Peripheral-bus output stage: turns an access request (enable, direction,
// register offset, data) into PerAddr/PerDOut/PerWr/PerEn, holding the
// address, data and strobes at zero whenever no access is enabled so the
// external arbiter can OR/mux them cleanly.
module param_burst_master_per_bus_drive
   import param_burst_master_pkg::*;
#(
   parameter logic [15:0] BaseAddr = 16'h0188
) (
   input  logic        en,
   input  logic        write,
   input  logic [13:0] ofs,
   input  logic [15:0] data,
   output logic [13:0] per_addr,
   output logic [15:0] per_dout,
   output logic [1:0]  per_wr,
   output logic        per_en
);

   // Gate address, data and strobes with the enable.
   // NOTE: every output gets a default first, so no path through the block infers a latch.
   always_comb begin
      per_en   = en;
      per_addr = '0;
      per_dout = '0;
      per_wr   = PER_RD;
      if (en) begin
         per_addr = word_addr(BaseAddr, ofs);
         per_wr   = write ? PER_WR_WORD : PER_RD;
         per_dout = write ? data : '0;
      end
   end

endmodule

// File: rtl/param_burst_master.sv
// Burst initiator for the parameterization-interface register pair (address
// register + auto-incrementing data register) on an openMSP430-style
// peripheral bus. A local controller issues a command (read/write, start
// address, word count); the block writes the address register once, then
// streams words through the data register.
// Optional build macro PARAM_BURST_MASTER_TIMEOUT_EN adds a write-stream
// stall timeout that aborts the burst and pulses Error_o with Done_o.
module param_burst_master
   import param_burst_master_pkg::*;
#(
   parameter logic [15:0] BaseAddr      = 16'h0188,
   parameter int          AddrWidth     = 3,
   parameter int          CountWidth    = 4,
   parameter int          TimeoutCycles = 255
) (
   input  logic                  Clk_i,
   input  logic                  Reset_i,
   input  logic                  Cmd_Valid_i,
   output logic                  Cmd_Ready_o,
   input  logic                  Cmd_Read_i,
   input  logic [AddrWidth-1:0]  Cmd_Addr_i,
   input  logic [CountWidth-1:0] Cmd_Count_i,
   input  logic [15:0]           WrData_i,
   input  logic                  WrData_Valid_i,
   output logic                  WrData_Ready_o,
   output logic [15:0]           RdData_o,
   output logic                  RdData_Valid_o,
   input  logic                  RdData_Ready_i,
   output logic                  Busy_o,
   output logic                  Done_o,
   output logic                  Error_o,
   output logic [13:0]           PerAddr_o,
   output logic [15:0]           PerDOut_o,
   output logic [1:0]            PerWr_o,
   output logic                  PerEn_o,
   input  logic [15:0]           PerDIn_i
);

   state_t                state;
   logic                  read_q;
   logic [AddrWidth-1:0]  addr_q;
   logic [CountWidth-1:0] remain_q;
   logic [15:0]           rd_data_q;
   logic                  rd_valid_q;

   logic                  wr_take;
   logic                  last_word;
   logic                  timeout_hit;

   logic                  bus_en;
   logic                  bus_write;
   logic [13:0]           bus_ofs;
   logic [15:0]           bus_data;

   // A write word is consumed in the same cycle it is offered while streaming.
   assign wr_take   = (state == WR) && WrData_Valid_i;
   assign last_word = (remain_q == CountWidth'(1));

`ifdef PARAM_BURST_MASTER_TIMEOUT_EN
   localparam int TmoWidth = $clog2(TimeoutCycles + 1);

   logic [TmoWidth-1:0] tmo_q;
   logic                error_q;

   assign timeout_hit = (state == WR) && !WrData_Valid_i &&
                        (tmo_q == TmoWidth'(TimeoutCycles - 1));
   assign Error_o     = error_q;

   // Stall counter: counts idle WR cycles, cleared by any consumed word or other state.
   always_ff @(posedge Clk_i) begin
      if (Reset_i) begin
         tmo_q   <= '0;
         error_q <= 1'b0;
      end else begin
         error_q <= timeout_hit;
         if ((state != WR) || WrData_Valid_i) tmo_q <= '0;
         else                                 tmo_q <= tmo_q + TmoWidth'(1);
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign Error_o     = 1'b0;

   // TimeoutCycles only sizes the stall counter, which this build leaves out.
   if (TimeoutCycles < 1) begin : g_timeout_unused
   end
`endif

   // Burst sequencer: command latch, remaining-count tracking and read capture.
   // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
   always_ff @(posedge Clk_i) begin
      if (Reset_i) begin
         state      <= IDLE;
         read_q     <= 1'b0;
         addr_q     <= '0;
         remain_q   <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (Cmd_Valid_i) begin
                  read_q   <= Cmd_Read_i;
                  addr_q   <= Cmd_Addr_i;
                  remain_q <= Cmd_Count_i;
                  state    <= (Cmd_Count_i == '0) ? DONE : ADDR;
               end
            end
            ADDR: state <= read_q ? RD : WR;
            WR: begin
               if (wr_take) begin
                  remain_q <= remain_q - CountWidth'(1);
                  if (last_word) state <= DONE;
               end else if (timeout_hit) begin
                  state <= DONE;
               end
            end
            RD: state <= RDCAP;
            RDCAP: begin
               rd_data_q  <= PerDIn_i;
               rd_valid_q <= 1'b1;
               state      <= RDHOLD;
            end
            RDHOLD: begin
               if (RdData_Ready_i) begin
                  rd_valid_q <= 1'b0;
                  remain_q   <= remain_q - CountWidth'(1);
                  state      <= last_word ? DONE : RD;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Select the bus access for the current state.
   always_comb begin
      bus_en    = 1'b0;
      bus_write = 1'b0;
      bus_ofs   = OFS_ADDR;
      bus_data  = '0;
      unique case (state)
         ADDR: begin
            bus_en    = 1'b1;
            bus_write = 1'b1;
            bus_ofs   = OFS_ADDR;
            bus_data  = 16'(addr_q);
         end
         WR: begin
            bus_en    = WrData_Valid_i;
            bus_write = 1'b1;
            bus_ofs   = OFS_DATA;
            bus_data  = WrData_i;
         end
         RD: begin
            bus_en  = 1'b1;
            bus_ofs = OFS_DATA;
         end
         default: ;
      endcase
   end

   param_burst_master_per_bus_drive #(
      .BaseAddr (BaseAddr)
   ) u_bus (
      .en       (bus_en),
      .write    (bus_write),
      .ofs      (bus_ofs),
      .data     (bus_data),
      .per_addr (PerAddr_o),
      .per_dout (PerDOut_o),
      .per_wr   (PerWr_o),
      .per_en   (PerEn_o)
   );

   assign Cmd_Ready_o    = (state == IDLE);
   assign Busy_o         = (state != IDLE);
   assign Done_o         = (state == DONE);
   assign WrData_Ready_o = wr_take;
   assign RdData_o       = rd_data_q;
   assign RdData_Valid_o = rd_valid_q;

endmodule

// File: tb/tb_param_burst_master.sv
// Self-checking bench for param_burst_master. A behavioural responder models
// the address/auto-increment data register pair; a reference memory tracks
// what each parameter should hold, and every burst is compared against the
// bus accesses, read words and Done timing expected from the command alone.
module tb_param_burst_master;

   localparam int          AW   = 3;
   localparam int          CW   = 4;
   localparam int          TMO  = 8;
   localparam logic [15:0] BASE = 16'h0188;
   localparam logic [13:0] A_REG = 14'(BASE / 2);
   localparam logic [13:0] D_REG = 14'(BASE / 2 + 1);

   logic          clk = 1'b0;
   logic          Reset_i = 1'b1;
   logic          Cmd_Valid_i = 1'b0;
   logic          Cmd_Ready_o;
   logic          Cmd_Read_i = 1'b0;
   logic [AW-1:0] Cmd_Addr_i = '0;
   logic [CW-1:0] Cmd_Count_i = '0;
   logic [15:0]   WrData_i = '0;
   logic          WrData_Valid_i = 1'b0;
   logic          WrData_Ready_o;
   logic [15:0]   RdData_o;
   logic          RdData_Valid_o;
   logic          RdData_Ready_i = 1'b0;
   logic          Busy_o, Done_o, Error_o;
   logic [13:0]   PerAddr_o;
   logic [15:0]   PerDOut_o;
   logic [1:0]    PerWr_o;
   logic          PerEn_o;
   logic [15:0]   PerDIn_i = '0;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   typedef struct {
      logic [13:0] addr;
      logic [15:0] dout;
      logic [1:0]  wr;
      int          t;
   } bus_t;

   bus_t        bus_q[$];
   logic [15:0] rd_q[$];
   int          rd_t[$];
   int          done_cnt = 0;
   int          done_t = 0;
   int          err_cnt = 0;
   bit          started = 1'b0;
   bit          hold_prev = 1'b0;
   logic [15:0] hold_data = '0;

   logic [15:0] resp_mem [32];
   logic [15:0] resp_ptr = '0;
   logic [15:0] ref_mem [32];

   param_burst_master #(
      .BaseAddr      (BASE),
      .AddrWidth     (AW),
      .CountWidth    (CW),
      .TimeoutCycles (TMO)
   ) dut (
      .Clk_i          (clk),
      .Reset_i        (Reset_i),
      .Cmd_Valid_i    (Cmd_Valid_i),
      .Cmd_Ready_o    (Cmd_Ready_o),
      .Cmd_Read_i     (Cmd_Read_i),
      .Cmd_Addr_i     (Cmd_Addr_i),
      .Cmd_Count_i    (Cmd_Count_i),
      .WrData_i       (WrData_i),
      .WrData_Valid_i (WrData_Valid_i),
      .WrData_Ready_o (WrData_Ready_o),
      .RdData_o       (RdData_o),
      .RdData_Valid_o (RdData_Valid_o),
      .RdData_Ready_i (RdData_Ready_i),
      .Busy_o         (Busy_o),
      .Done_o         (Done_o),
      .Error_o        (Error_o),
      .PerAddr_o      (PerAddr_o),
      .PerDOut_o      (PerDOut_o),
      .PerWr_o        (PerWr_o),
      .PerEn_o        (PerEn_o),
      .PerDIn_i       (PerDIn_i)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Responder: address register loads the pointer; data register accesses
   // use and bump it. Read data is valid only in the cycle after the access.
   always @(posedge clk) begin
      PerDIn_i <= 16'($urandom);
      if (PerEn_o) begin
         if (PerWr_o == 2'b11 && PerAddr_o == A_REG) begin
            resp_ptr <= PerDOut_o;
         end else if (PerAddr_o == D_REG) begin
            if (PerWr_o == 2'b11) resp_mem[resp_ptr[4:0]] = PerDOut_o;
            else                  PerDIn_i <= resp_mem[resp_ptr[4:0]];
            resp_ptr <= resp_ptr + 16'd1;
         end
      end
   end

   // Monitor: log bus accesses and accepted reads, check idle-bus gating,
   // read-hold stability and Done/Error pulses.
   always @(negedge clk) begin
      if (Reset_i || !started) begin
         hold_prev = 1'b0;
      end else begin
         if (PerEn_o) bus_q.push_back('{PerAddr_o, PerDOut_o, PerWr_o, cyc});
         else check("bus_idle_zero", {PerAddr_o, PerDOut_o, PerWr_o}, 64'd0);
         if (hold_prev) begin
            check("rd_hold_valid", RdData_Valid_o, 1);
            check("rd_hold_data", RdData_o, hold_data);
         end
         hold_prev = RdData_Valid_o && !RdData_Ready_i;
         hold_data = RdData_o;
         if (RdData_Valid_o && RdData_Ready_i) begin
            rd_q.push_back(RdData_o);
            rd_t.push_back(cyc);
         end
         if (Done_o) begin
            done_cnt++;
            done_t = cyc;
         end
         if (Error_o) begin
            err_cnt++;
            check("error_with_done", Done_o, 1);
         end
      end
   end

   // mode 0: continuous data / ready, 1: random gaps, 2: ready held low 5 cycles.
   task automatic run_cmd(input bit rd, input int a, input int n, input int mode, input bit fixed);
      logic [15:0] wdata [16];
      logic [31:0] exp_bus;
      int idx, budget, hold, d0, t_acc, e, period, exp_t;
      bit take;
      for (int i = 0; i < 16; i++) wdata[i] = fixed ? 16'(16'h1111 * (i + 1)) : 16'($urandom);
      bus_q.delete();
      rd_q.delete();
      rd_t.delete();
      d0 = done_cnt;
      check("cmd_ready_idle", Cmd_Ready_o, 1);
      Cmd_Valid_i = 1'b1;
      Cmd_Read_i  = rd;
      Cmd_Addr_i  = AW'(a);
      Cmd_Count_i = CW'(n);
      @(posedge clk); #1;
      t_acc       = cyc;
      Cmd_Valid_i = 1'b0;
      Cmd_Read_i  = 1'($urandom);
      Cmd_Addr_i  = AW'($urandom);
      Cmd_Count_i = CW'($urandom);
      check("busy_after_accept", {Busy_o, Cmd_Ready_o}, 2'b10);
      idx = 0; hold = 0; budget = 0;
      while (done_cnt == d0 && budget < 400) begin
         Cmd_Valid_i    = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
         WrData_Valid_i = (idx < n) && (mode != 1 || $urandom_range(0, 2) != 0);
         WrData_i       = (idx < n) ? wdata[idx] : 16'($urandom);
         RdData_Ready_i = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : (hold >= 5);
         @(negedge clk);
         take = WrData_Valid_i && WrData_Ready_o;
         if (RdData_Valid_o && !RdData_Ready_i) hold++;
         else if (RdData_Valid_o)               hold = 0;
         @(posedge clk); #1;
         if (take) idx++;
         budget++;
      end
      Cmd_Valid_i    = 1'b0;
      WrData_Valid_i = 1'b0;
      RdData_Ready_i = 1'b0;
      check("done_seen", done_cnt - d0, 1);
      check("idle_after_done", Busy_o, 0);
      @(negedge clk);
      check("single_done", done_cnt - d0, 1);
      @(posedge clk); #1;

      period = (mode == 2) ? 8 : 3;
      if (mode != 1) begin
         exp_t = (n == 0) ? t_acc : rd ? t_acc + period * n + 1 : t_acc + n + 1;
         check("done_time", done_t, exp_t);
      end
      e = (n == 0) ? 0 : n + 1;
      check("bus_count", bus_q.size(), e);
      if (bus_q.size() == e) begin
         for (int i = 0; i < e; i++) begin
            if (i == 0)  exp_bus = {A_REG, 16'(a), 2'b11};
            else if (rd) exp_bus = {D_REG, 16'h0000, 2'b00};
            else         exp_bus = {D_REG, wdata[i-1], 2'b11};
            check("bus_access", {bus_q[i].addr, bus_q[i].dout, bus_q[i].wr}, exp_bus);
            if (mode != 1) begin
               exp_t = (i == 0) ? t_acc : rd ? t_acc + 1 + period * (i - 1) : t_acc + i;
               check("bus_time", bus_q[i].t, exp_t);
            end
         end
      end
      check("rd_count", rd_q.size(), rd ? n : 0);
      if (rd) begin
         for (int i = 0; i < rd_q.size() && i < n; i++) begin
            check("rd_data", rd_q[i], ref_mem[a + i]);
            if (mode == 0) check("rd_time", rd_t[i], t_acc + 3 + 3 * i);
         end
      end else begin
         for (int i = 0; i < n; i++) ref_mem[a + i] = wdata[i];
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [15:0] v;
      logic [15:0] w0;
      int d0, e0, t_acc, budget;
      for (int i = 0; i < 32; i++) begin
         v           = 16'($urandom);
         resp_mem[i] = v;
         ref_mem[i]  = v;
      end

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("reset_cmd_ready", Cmd_Ready_o, 1);
      check("reset_outputs",
            {WrData_Ready_o, RdData_o, RdData_Valid_o, Busy_o, Done_o, Error_o,
             PerAddr_o, PerDOut_o, PerWr_o, PerEn_o}, 64'd0);
      Reset_i = 1'b0;
      started = 1'b1;

      // Directed: write Addr=2 Count=3 with 1111/2222/3333
      run_cmd(1'b0, 2, 3, 0, 1'b1);

      // Directed: read Addr=1 Count=2 returning ABCD, 0042
      resp_mem[1] = 16'hABCD; ref_mem[1] = 16'hABCD;
      resp_mem[2] = 16'h0042; ref_mem[2] = 16'h0042;
      run_cmd(1'b1, 1, 2, 0, 1'b0);

      // Read with ready held low 5 cycles per word
      run_cmd(1'b1, 5, 2, 2, 1'b0);

      // Zero-count commands
      run_cmd(1'b0, 3, 0, 0, 1'b0);
      run_cmd(1'b1, 6, 0, 0, 1'b0);

      // Maximum bursts
      run_cmd(1'b0, 0, 15, 0, 1'b0);
      run_cmd(1'b1, 0, 15, 0, 1'b0);

      // Reset during word 2 of a 4-word write
      d0 = done_cnt;
      w0 = 16'($urandom);
      Cmd_Valid_i = 1'b1; Cmd_Read_i = 1'b0; Cmd_Addr_i = 3'd4; Cmd_Count_i = 4'd4;
      @(posedge clk); #1;
      Cmd_Valid_i    = 1'b0;
      WrData_Valid_i = 1'b1;
      WrData_i       = w0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      WrData_Valid_i = 1'b0;
      WrData_i       = 16'($urandom);
      Reset_i        = 1'b1;
      @(posedge clk); #1;
      Reset_i = 1'b0;
      check("midreset_cmd_ready", Cmd_Ready_o, 1);
      check("midreset_outputs",
            {WrData_Ready_o, RdData_o, RdData_Valid_o, Busy_o, Done_o, Error_o,
             PerAddr_o, PerDOut_o, PerWr_o, PerEn_o}, 64'd0);
      repeat (3) @(posedge clk);
      #1;
      check("midreset_no_done", done_cnt - d0, 0);
      ref_mem[4] = w0;

      // Randomized bursts
      for (int k = 0; k < 24; k++) begin
         run_cmd(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 1)), 1'b0);
      end

`ifdef PARAM_BURST_MASTER_TIMEOUT_EN
      // Write Count=2 with only one word supplied
      d0 = done_cnt;
      e0 = err_cnt;
      bus_q.delete();
      Cmd_Valid_i = 1'b1; Cmd_Read_i = 1'b0; Cmd_Addr_i = 3'd1; Cmd_Count_i = 4'd2;
      @(posedge clk); #1;
      t_acc          = cyc;
      Cmd_Valid_i    = 1'b0;
      WrData_Valid_i = 1'b1;
      WrData_i       = 16'h5A5A;
      @(posedge clk); #1;
      @(posedge clk); #1;
      WrData_Valid_i = 1'b0;
      budget = 0;
      while (done_cnt == d0 && budget < 40) begin
         @(posedge clk); #1;
         budget++;
      end
      check("tmo_done", done_cnt - d0, 1);
      check("tmo_error", err_cnt - e0, 1);
      check("tmo_done_time", done_t, t_acc + 10);
      check("tmo_bus_count", bus_q.size(), 2);
      ref_mem[1] = 16'h5A5A;
      run_cmd(1'b1, 1, 1, 0, 1'b0);
`else
      check("no_error_pulse", err_cnt, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
